// File: rtl/ctech_lib_wake_or_sync.sv
// ---------------------------------------------------------------------------
// ctech_lib_wake_or_sync
//
// Wake/event aggregator placed directly upstream of the ctech_lib_or cells.
// Asynchronous request lines are synchronized into clk and rising-edge
// detected into sticky pending bits. The pending bits are OR-reduced into a
// single registered wake output that, once asserted, stays high for at least
// MIN_HOLD cycles. Firmware clears pending bits through a four-phase
// req/ack handshake.
//
// Optional feature macro: CTECH_LIB_WAKE_GLITCH_FILTER_EN
//   When defined, a synced level must stay high for two consecutive cycles
//   before it counts as an edge. Single-cycle synced pulses are ignored, and
//   source-to-pend latency grows by one cycle.
//
// Parameters
//   NUM_SRC     number of request sources (1..16)
//   SYNC_STAGES synchronizer depth (2..3)
//   MIN_HOLD    minimum wake_o high time in cycles (1..15)
//
// Ports
//   clk        in   sole clock
//   rst_b      in   asynchronous assert, active-low reset
//   src_async  in   [NUM_SRC] asynchronous level requests
//   src_mask   in   [NUM_SRC] per-source enable (1 = enabled), clk domain
//   clr_req    in   four-phase clear request
//   clr_vec    in   [NUM_SRC] bits to clear, stable while clr_req is high
//   clr_ack    out  one-cycle clear acknowledge
//   pend       out  [NUM_SRC] sticky pending bits
//   wake_o     out  aggregated, registered wake
// ---------------------------------------------------------------------------
module ctech_lib_wake_or_sync #(
  parameter int NUM_SRC     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HOLD    = 3
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic [NUM_SRC-1:0] src_async,
  input  logic [NUM_SRC-1:0] src_mask,
  input  logic               clr_req,
  input  logic [NUM_SRC-1:0] clr_vec,
  output logic               clr_ack,
  output logic [NUM_SRC-1:0] pend,
  output logic               wake_o
);

  localparam logic [3:0] HOLD_LOAD = 4'(MIN_HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACK      = 2'd1,
    ST_WAIT_LOW = 2'd2
  } clr_state_t;

  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] r_sync;
  logic [NUM_SRC-1:0]                  w_s_sync;
  logic [NUM_SRC-1:0]                  w_edge;
  logic [NUM_SRC-1:0]                  w_set;
  logic [NUM_SRC-1:0]                  w_clr_bits;
  logic [NUM_SRC-1:0]                  r_pend;
  logic                                w_any;
  logic [3:0]                          r_hold_cnt;
  logic                                r_wake;
  clr_state_t                          r_state;
  clr_state_t                          w_state_nxt;
  logic                                r_clr_ack;

  // Synchronizer chain: stage 0 samples the raw asynchronous inputs.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], src_async};
    end
  end

  assign w_s_sync = r_sync[SYNC_STAGES-1];

`ifdef CTECH_LIB_WAKE_GLITCH_FILTER_EN
  logic [NUM_SRC-1:0] r_s_filt;
  logic [NUM_SRC-1:0] r_s_prev2;

  // Filter history: s_filt is the synced level one cycle ago, s_prev2 two ago.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_s_filt  <= '0;
      r_s_prev2 <= '0;
    end else begin
      r_s_filt  <= w_s_sync;
      r_s_prev2 <= r_s_filt;
    end
  end

  // An edge needs the synced level high for two consecutive cycles after a low.
  assign w_edge = w_s_sync & r_s_filt & ~r_s_prev2;
`else
  logic [NUM_SRC-1:0] r_s_prev;

  // Previous synced level for plain rising-edge detection.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_s_prev <= '0;
    end else begin
      r_s_prev <= w_s_sync;
    end
  end

  assign w_edge = w_s_sync & ~r_s_prev;
`endif

  // Masked edges are dropped outright; the mask never touches pend itself.
  assign w_set = w_edge & src_mask;

  // The clear lands at the edge that ends the ACK cycle.
  assign w_clr_bits = (r_state == ST_ACK) ? clr_vec : '0;

  // Clear handshake next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (clr_req) begin
          w_state_nxt = ST_ACK;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACK: begin
        w_state_nxt = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        if (!clr_req) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT_LOW;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Clear FSM state register; ack is registered alongside so it tracks ST_ACK.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state   <= ST_IDLE;
      r_clr_ack <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ack <= (w_state_nxt == ST_ACK);
    end
  end

  // Sticky pending bits; a set wins over a clear of the same bit.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr_bits) | w_set;
    end
  end

  // Reduction that maps onto the downstream ctech_lib_or cell tree.
  assign w_any = |r_pend;

  // Wake output with minimum-hold counter; only a 0->1 of wake loads it.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_wake     <= 1'b0;
      r_hold_cnt <= 4'd0;
    end else if (r_hold_cnt != 4'd0) begin
      r_hold_cnt <= r_hold_cnt - 4'd1;
      r_wake     <= 1'b1;
    end else if (!r_wake && w_any) begin
      r_wake     <= 1'b1;
      r_hold_cnt <= HOLD_LOAD;
    end else begin
      r_wake     <= w_any;
      r_hold_cnt <= 4'd0;
    end
  end

  assign clr_ack = r_clr_ack;
  assign pend    = r_pend;
  assign wake_o  = r_wake;

endmodule

// File: tb/tb_ctech_lib_wake_or_sync.sv
// ---------------------------------------------------------------------------
// Testbench for ctech_lib_wake_or_sync (default parameters).
// A reference model samples the inputs at every rising edge, works out the
// expected outputs from the block's behavioural rules (delayed sample
// history, handshake rule, hold window) and queues them. A monitor on the
// falling edge pops each entry and compares it with the DUT outputs.
// Directed sequences cover reset, masking, minimum hold, set/clear collision
// and handshake discipline; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_ctech_lib_wake_or_sync;

  localparam int NS = 4;
  localparam int SS = 2;
  localparam int MH = 3;

  logic          clk;
  logic          rst_b;
  logic [NS-1:0] src_async;
  logic [NS-1:0] src_mask;
  logic          clr_req;
  logic [NS-1:0] clr_vec;
  logic          clr_ack;
  logic [NS-1:0] pend;
  logic          wake_o;

  typedef struct {
    logic [NS-1:0] pend;
    logic          wake;
    logic          ack;
    int            cyc;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  ctech_lib_wake_or_sync #(
    .NUM_SRC    (NS),
    .SYNC_STAGES(SS),
    .MIN_HOLD   (MH)
  ) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .src_async(src_async),
    .src_mask (src_mask),
    .clr_req  (clr_req),
    .clr_vec  (clr_vec),
    .clr_ack  (clr_ack),
    .pend     (pend),
    .wake_o   (wake_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: expected outputs after each rising edge.
  initial begin
    logic [NS-1:0] hist [0:7];
    logic [NS-1:0] m_pend;
    logic [NS-1:0] set_v;
    logic [NS-1:0] clr_v;
    logic          m_wake;
    logic          m_ack;
    logic          m_ready;
    logic          any_before;
    logic          wake_new;
    int            n;
    int            rise_n;
    exp_t          e;
    m_pend  = '0;
    m_wake  = 1'b0;
    m_ack   = 1'b0;
    m_ready = 1'b1;
    n       = 0;
    rise_n  = -100;
    for (int i = 0; i < 8; i++) hist[i] = '0;
    forever begin
      @(posedge clk);
      n = n + 1;
      if (!rst_b) begin
        for (int i = 0; i < 8; i++) hist[i] = '0;
        m_pend  = '0;
        m_wake  = 1'b0;
        m_ack   = 1'b0;
        m_ready = 1'b1;
      end else begin
        for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = src_async;
        // hist[k] is the source level sampled k edges ago.
`ifdef CTECH_LIB_WAKE_GLITCH_FILTER_EN
        set_v = hist[SS] & hist[SS+1] & ~hist[SS+2] & src_mask;
`else
        set_v = hist[SS] & ~hist[SS+1] & src_mask;
`endif
        clr_v      = m_ack ? clr_vec : '0;
        any_before = (m_pend != '0);
        if (m_wake && ((n - rise_n) < MH)) wake_new = 1'b1;
        else wake_new = any_before;
        if (!m_wake && wake_new) rise_n = n;
        m_wake = wake_new;
        m_pend = (m_pend & ~clr_v) | set_v;
        // One ack per request; a low request must be seen after an ack ends.
        if (m_ack) begin
          m_ack   = 1'b0;
          m_ready = 1'b0;
        end else if (m_ready && clr_req) begin
          m_ack   = 1'b1;
          m_ready = 1'b0;
        end else if (!m_ready && !clr_req) begin
          m_ready = 1'b1;
        end
      end
      e.pend = m_pend;
      e.wake = m_wake;
      e.ack  = m_ack;
      e.cyc  = n;
      sb_q.push_back(e);
    end
  end

  task automatic chk(input string nm, input int cyc, input logic [NS-1:0] act,
                     input logic [NS-1:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("pend", e.cyc, pend, e.pend);
        chk("wake_o", e.cyc, {3'b000, wake_o}, {3'b000, e.wake});
        chk("clr_ack", e.cyc, {3'b000, clr_ack}, {3'b000, e.ack});
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_clear(input logic [NS-1:0] v);
    tick();
    clr_vec = v;
    clr_req = 1'b1;
    tick();
    tick();
    clr_req = 1'b0;
    tick();
  endtask

  // Stimulus: directed sequences, then randomized traffic.
  initial begin
    rst_b     = 1'b0;
    src_async = 4'hF;
    src_mask  = 4'hF;
    clr_req   = 1'b0;
    clr_vec   = 4'h0;
    repeat (3) tick();
    rst_b = 1'b1;
    repeat (8) tick();
    src_async = 4'h0;
    do_clear(4'hF);
    repeat (6) tick();

    // Masked source plus immediate clear exercises the minimum hold.
    src_mask  = 4'b0101;
    src_async = 4'b0110;
    repeat (3) tick();
    do_clear(4'b0100);
    repeat (6) tick();
    src_async = 4'h0;
    src_mask  = 4'hF;
    repeat (4) tick();

    // Clear edge coincides with the pend-set edge of source 0.
    src_async = 4'b0001;
    do_clear(4'b0001);
    repeat (6) tick();
    src_async = 4'h0;

    // Long request, short low gap, re-raise.
    clr_vec = 4'h0;
    clr_req = 1'b1;
    repeat (6) tick();
    clr_req = 1'b0;
    tick();
    clr_req = 1'b1;
    repeat (3) tick();
    clr_req = 1'b0;
    repeat (3) tick();

    // One-cycle pulse on source 3.
    src_async = 4'b1000;
    tick();
    src_async = 4'h0;
    repeat (8) tick();
    do_clear(4'hF);
    repeat (6) tick();

    // Randomized traffic with a mid-run reset.
    for (int c = 0; c < 600; c++) begin
      src_async = src_async ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      if ($urandom_range(0, 15) == 0) src_mask = 4'($urandom);
      if (clr_req) begin
        if ($urandom_range(0, 2) == 0) clr_req = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        clr_vec = 4'($urandom);
        clr_req = 1'b1;
      end
      if (c == 300) rst_b = 1'b0;
      if (c == 302) rst_b = 1'b1;
      tick();
    end
    clr_req = 1'b0;
    repeat (5) tick();

    total = total + 1;
    if (sb_q.size() > 1) begin
      bad = bad + 1;
      $display("FAIL scoreboard_drain left=%0d expected<=1", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctech_lib_wake_or_sync.md
# ctech_lib_wake_or_sync

Asynchronous wake/event aggregator that sits directly upstream of the `ctech_lib_or` cells. It synchronizes up to `NUM_SRC` asynchronous request lines into `clk` and edge-detects them into sticky pending bits. The pending bits are OR-reduced through the OR library cells into a single registered, minimum-hold `wake_o` for the power/interrupt controller. Software or firmware clears pending bits through a four-phase req/ack handshake.

## Interface
- `NUM_SRC`, 4: number of request sources; legal 1..16.
- `SYNC_STAGES`, 2: synchronizer depth; legal 2..3.
- `MIN_HOLD`, 3: minimum cycles `wake_o` stays high once asserted; legal 1..15.

- `clk`  in  1  sole clock.
- `rst_b`  in  1  reset; asynchronous assert, active-low. Deassertion is synchronous to `clk` externally.
- `src_async`  in  NUM_SRC  asynchronous level requests.
- `src_mask`  in  NUM_SRC  per-source enable; 1 = enabled; synchronous to `clk`.
- `clr_req`  in  1  clear request, four-phase.
- `clr_vec`  in  NUM_SRC  bits to clear; stable while `clr_req`=1.
- `clr_ack`  out  1  clear acknowledge, one-cycle pulse.
- `pend`  out  NUM_SRC  sticky pending bits.
- `wake_o`  out  1  aggregated wake, registered.

## Operation
- **Synchronizer.** Each `src_async` bit passes through a `SYNC_STAGES`-deep flop chain, giving `s_sync`. `s_prev` registers `s_sync`.
- **Rising edge.** `edge = s_sync & ~s_prev`.
- **Pending set.** `pend[i]` sets on `edge[i] & src_mask[i]`.
  - A masked edge is dropped; it is not deferred.
  - Changing `src_mask` never alters `pend`.
- **Clear FSM:**
  - IDLE: if `clr_req`=1, go to ACK.
  - ACK: `clr_ack`=1 for exactly this cycle. At the ending edge, `pend &= ~clr_vec`. Go to WAIT_LOW.
  - WAIT_LOW: stay until `clr_req`=0, then go to IDLE. No second ack until `clr_req` has been seen low.
- **Set/clear collision.** If a set and a clear hit the same bit at the same edge, the set wins and the bit stays 1.
- **Wake output:**
  - `any = |pend`, built from the OR cell tree.
  - On a 0->1 transition, `wake_o` rises and `hold_cnt` loads `MIN_HOLD-1`.
  - While `hold_cnt`!=0, `hold_cnt` decrements and `wake_o` stays 1 regardless of `any`.
  - When `hold_cnt`==0, `wake_o` follows `any`.
  - A new rise after a fall reloads `hold_cnt`. `any` staying high does not reload it.
- **Counter width.** `hold_cnt` is 4 bits and never wraps below 0.

## Timing
- **Reset values.** All outputs are 0 during and after reset: `pend`=0, `wake_o`=0, `clr_ack`=0. Sync chain=0, `s_prev`=0, `hold_cnt`=0, FSM=IDLE.
- **Reset mid-operation.** Reset assertion immediately aborts a handshake and clears pending state. A `src_async` already high at reset release produces an edge, and therefore a pend, once synchronized.
- **Source to pend.** `src_async` rising before edge 0 gives `pend` high after edge `SYNC_STAGES+1`.
- **Pend to wake.** `wake_o` is high one edge after `pend`.
- **Clear timing.** `clr_req` sampled high at edge k gives `clr_ack` high between edges k and k+1. `pend` shows the clear after edge k+1.
- **Clear latency.** `clr_req`->`clr_ack` latency is 1 cycle. Minimum handshake period is 3 cycles.
- **Minimum wake pulse.** `wake_o` pulses are at least `MIN_HOLD` cycles wide.

## Configuration
- Macro: `CTECH_LIB_WAKE_GLITCH_FILTER_EN`.
- **Defined:**
  - An extra per-bit register `s_filt` tracks `s_sync`.
  - Edge becomes `s_sync & s_filt & ~s_prev2`, where `s_prev2` registers `s_filt`. The synced level must be high for 2 consecutive cycles.
  - A synced pulse lasting 1 cycle is ignored.
  - Source->pend latency grows by 1 cycle, to `SYNC_STAGES+2`.
- **Undefined:** plain edge detect as described in Operation; no extra flops.

## Test plan
- **Reset.** Hold `rst_b`=0 with `src_async`=4'hF. -> `pend`=0, `wake_o`=0, `clr_ack`=0. After release with defaults: `pend`=4'hF at edge 3, `wake_o`=1 at edge 4.
- **Masked source and minimum hold.**
  - Stimulus: `src_mask`=4'b0101. Raise `src_async[1]` and `src_async[2]`.
  - Response: `pend`=4'b0100 only; `wake_o` rises.
  - Then clear 4'b0100 immediately. -> `wake_o` stays high exactly `MIN_HOLD`=3 cycles, then drops.
- **Set/clear collision.** `clr_vec`=4'b0001 with `clr_req` timed so that the clear edge coincides with the `src_async[0]` pend-set edge. -> `pend[0]`=1 and `clr_ack` pulses once.
- **Handshake discipline.**
  - Hold `clr_req`=1 for 6 cycles. -> exactly one `clr_ack` pulse.
  - Drop `clr_req` for 1 cycle, then raise it again. -> a second ack arrives 1 cycle after the re-raise.
- **Filter enabled.** With `CTECH_LIB_WAKE_GLITCH_FILTER_EN`:
  - A 1-cycle synchronous high on `src_async[3]` -> no `pend`.
  - A 3-cycle high -> `pend[3]` at edge 4.
- **Filter disabled.** Without the macro, the same 1-cycle pulse -> `pend[3]`=1.
